// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the value source and the seven-segment scan driver.
// The source side (master) drives the display value and live controls; the
// driver side (slave) returns the pin-level anode/segment signals.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIM_BITS   = 3
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic                    hex_mode;
    logic [DIM_BITS-1:0]     brightness;
    logic [6:0]              Led_Disp;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, load, blank_lz, hex_mode, brightness,
        input  Led_Disp, dp, anode, frame_done
    );

    modport slave (
        input  digits_in, dp_in, load, blank_lz, hex_mode, brightness,
        output Led_Disp, dp, anode, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver. A prescaler sets the slot
// length, a digit index walks the slots, and a shadow/active register pair
// swaps only at the frame wrap so a digit never shows half of an update.
// Leading-zero blanking, per-digit decimal points, hex/BCD glyphs and PWM
// brightness are applied when the registered pin outputs are formed.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIM_BITS    = 3
) (
    input  logic                    Clk,
    input  logic                    reset,
    seg7_scan_driver_if.slave       bus
);
    localparam int PW    = $clog2(REFRESH_DIV);
    localparam int IW    = $clog2(NUM_DIGITS);
    localparam int PRODW = PW + DIM_BITS + 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           p_q, p_d;
    logic [IW-1:0]           i_q, i_d;
    logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              led_q, led_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;

    logic                    slot_end, frame_wrap, lit, blanked, upper_nonzero;
    logic [PRODW-1:0]        on_prod, on_thr;
    logic [3:0]              cur_nib;
    logic                    cur_dp;

    // Active-low {g,f,e,d,c,b,a} pattern; BCD mode turns 10..15 into a dash.
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
        endcase
        if (!hex && nib > 4'd9) begin
            g = 7'b0111111;
        end
        return g;
    endfunction

    // Next-state for scan counters, buffers, and the pin image of the current slot.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned and infers a latch.
        p_d           = p_q;
        i_d           = i_q;
        sh_dig_d      = sh_dig_q;
        sh_dp_d       = sh_dp_q;
        act_dig_d     = act_dig_q;
        act_dp_d      = act_dp_q;
        led_d         = 7'h7F;
        dp_d          = 1'b1;
        anode_d       = '1;
        upper_nonzero = 1'b0;

        slot_end     = (p_q == P_LAST);
        frame_wrap   = slot_end && (i_q == I_LAST);
        frame_done_d = frame_wrap;

        p_d = slot_end ? '0 : p_q + PW'(1);
        if (slot_end) begin
            i_d = (i_q == I_LAST) ? '0 : i_q + IW'(1);
        end

        // The swap copies the pre-edge shadow, so a load on the wrap edge waits a frame.
        if (frame_wrap) begin
            act_dig_d = sh_dig_q;
            act_dp_d  = sh_dp_q;
        end
        if (bus.load) begin
            sh_dig_d = bus.digits_in;
            sh_dp_d  = bus.dp_in;
        end

        // Full-width product so the shift sees every bit of (brightness+1)*REFRESH_DIV.
        on_prod = (PRODW'(bus.brightness) + PRODW'(1)) * PRODW'(REFRESH_DIV);
        on_thr  = on_prod >> DIM_BITS;
        lit     = PRODW'(p_q) < on_thr;

        cur_nib = act_dig_q[4*i_q +: 4];
        cur_dp  = act_dp_q[i_q];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i_q) && act_dig_q[4*k +: 4] != 4'd0) begin
                upper_nonzero = 1'b1;
            end
        end
        blanked = bus.blank_lz && (i_q != '0) && !upper_nonzero;

        // A blanked digit still lights when its decimal point is requested.
        if (lit && !(blanked && !cur_dp)) begin
            anode_d = ~(NUM_DIGITS'(1) << i_q);
            led_d   = blanked ? 7'h7F : glyph(cur_nib, bus.hex_mode);
            dp_d    = ~cur_dp;
        end
    end

    // State and pin registers, synchronous active-high reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            p_q          <= '0;
            i_q          <= '0;
            sh_dig_q     <= '0;
            sh_dp_q      <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            frame_done_q <= 1'b0;
            led_q        <= 7'h7F;
            dp_q         <= 1'b1;
            anode_q      <= '1;
        end else begin
            p_q          <= p_d;
            i_q          <= i_d;
            sh_dig_q     <= sh_dig_d;
            sh_dp_q      <= sh_dp_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            frame_done_q <= frame_done_d;
            led_q        <= led_d;
            dp_q         <= dp_d;
            anode_q      <= anode_d;
        end
    end

    assign bus.Led_Disp   = led_q;
    assign bus.dp         = dp_q;
    assign bus.anode      = anode_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 8-cycle slots, 3-bit brightness.
// A reference model derived from elapsed-cycle arithmetic predicts every
// output each cycle; directed sections pin specific hand-computed values.
module tb_seg7_scan_driver;
    localparam int N = 4;
    localparam int R = 8;
    localparam int D = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(N), .DIM_BITS(D)) bus ();

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .DIM_BITS(D)) dut (
        .Clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] v, input logic hex);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        if (v > 4'd9 && !hex) return 7'b0111111;
        return t[v];
    endfunction

    // Reference model: position in the frame is elapsed cycles since reset.
    int         ph;
    logic [15:0] m_sh, m_act;
    logic [3:0]  m_shdp, m_actdp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_rst;

    always @(posedge clk) begin : model
        int p, i, thr;
        logic blanked, dpb;
        e_rst = reset;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            ph = 0; m_sh = '0; m_act = '0; m_shdp = '0; m_actdp = '0;
        end else begin
            p       = ph % R;
            i       = (ph / R) % N;
            thr     = ((int'(bus.brightness) + 1) * R) >> D;
            dpb     = m_actdp[i];
            blanked = bus.blank_lz && (i > 0) && ((m_act >> (4*i)) == 16'd0);
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (p < thr && !(blanked && !dpb)) begin
                e_an  = ~(4'b0001 << i);
                e_seg = blanked ? 7'h7F : ref_glyph(4'(m_act >> (4*i)), bus.hex_mode);
                e_dp  = ~dpb;
            end
            e_fd = (ph % (N*R)) == (N*R - 1);
            if (e_fd) begin
                m_act   = m_sh;
                m_actdp = m_shdp;
            end
            if (bus.load) begin
                m_sh   = bus.digits_in;
                m_shdp = bus.dp_in;
            end
            ph++;
        end
        #1;
        check("model anode", 32'(bus.anode), 32'(e_an));
        check("model frame_done", 32'(bus.frame_done), 32'(e_fd));
        if (e_an != 4'hF || e_rst) begin
            check("model Led_Disp", 32'(bus.Led_Disp), 32'(e_seg));
            check("model dp", 32'(bus.dp), 32'(e_dp));
        end
    end

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 400);
        check("frame_done seen", 32'(bus.frame_done), 32'd1);
    endtask

    // Leaves the bench at the first cycle of slot k in the next frame.
    task automatic goto_slot(input int k);
        int n;
        wait_fd(n);
        repeat (1 + 8*k) @(negedge clk);
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] dv);
        bus.digits_in = d;
        bus.dp_in     = dv;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic slot_pins(input string name, input logic [3:0] an, input logic [6:0] seg);
        check({name, " anode"}, 32'(bus.anode), 32'(an));
        check({name, " Led_Disp"}, 32'(bus.Led_Disp), 32'(seg));
    endtask

    task automatic duty_count(input int exp);
        int cnt = 0;
        for (int c = 0; c < R; c++) begin
            if (bus.anode[0] == 1'b0) cnt++;
            @(negedge clk);
        end
        check("duty cycles on", 32'(cnt), 32'(exp));
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        bus.digits_in  = '0;
        bus.dp_in      = '0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.hex_mode   = 1'b0;
        bus.brightness = 3'd7;

        // Reset held for three edges.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset anode", 32'(bus.anode), 32'hF);
            check("reset Led_Disp", 32'(bus.Led_Disp), 32'h7F);
            check("reset dp", 32'(bus.dp), 32'd1);
            check("reset frame_done", 32'(bus.frame_done), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        slot_pins("release", 4'b1110, 7'b1000000);

        wait_fd(n);
        wait_fd(n);
        check("frame period", 32'(n), 32'd32);

        // Double-buffered load mid-frame.
        repeat (10) @(negedge clk);
        load_val(16'h1234, 4'b0000);
        @(negedge clk);
        check("pre-swap unchanged", 32'(bus.Led_Disp), 32'(7'b1000000));
        goto_slot(0);
        slot_pins("1234 slot0", 4'b1110, 7'b0011001);
        repeat (8) @(negedge clk);
        slot_pins("1234 slot1", 4'b1101, 7'b0110000);
        repeat (8) @(negedge clk);
        slot_pins("1234 slot2", 4'b1011, 7'b0100100);
        repeat (8) @(negedge clk);
        slot_pins("1234 slot3", 4'b0111, 7'b1111001);

        // Leading-zero suppression.
        bus.blank_lz = 1'b1;
        load_val(16'h0050, 4'b0000);
        goto_slot(0);
        slot_pins("lz slot0", 4'b1110, 7'b1000000);
        repeat (8) @(negedge clk);
        slot_pins("lz slot1", 4'b1101, 7'b0010010);
        repeat (8) @(negedge clk);
        check("lz slot2 anode", 32'(bus.anode), 32'hF);
        repeat (8) @(negedge clk);
        check("lz slot3 anode", 32'(bus.anode), 32'hF);
        load_val(16'h0000, 4'b0000);
        goto_slot(0);
        slot_pins("zero slot0", 4'b1110, 7'b1000000);
        repeat (8) @(negedge clk);
        check("zero slot1 anode", 32'(bus.anode), 32'hF);
        load_val(16'h0050, 4'b1000);
        goto_slot(3);
        slot_pins("lz dp slot3", 4'b0111, 7'h7F);
        check("lz dp slot3 dp", 32'(bus.dp), 32'd0);

        // Glyph mode, switched live.
        load_val(16'h000A, 4'b0000);
        goto_slot(0);
        slot_pins("bcd A", 4'b1110, 7'b0111111);
        bus.hex_mode = 1'b1;
        @(negedge clk);
        check("hex A", 32'(bus.Led_Disp), 32'(7'b0001000));

        // Brightness duty.
        bus.blank_lz   = 1'b0;
        bus.brightness = 3'd0;
        goto_slot(0);
        duty_count(1);
        bus.brightness = 3'd3;
        goto_slot(0);
        duty_count(4);
        bus.brightness = 3'd7;
        goto_slot(0);
        duty_count(8);

        // Load coincident with the frame-wrap edge.
        wait_fd(n);
        repeat (31) @(negedge clk);
        load_val(16'h5678, 4'b0000);
        check("wrap frame_done", 32'(bus.frame_done), 32'd1);
        @(negedge clk);
        check("wrap load held back", 32'(bus.Led_Disp), 32'(7'b0001000));
        goto_slot(0);
        check("wrap load shown", 32'(bus.Led_Disp), 32'(7'b0000000));

        // Reset mid-slot 2 with a pending load.
        goto_slot(2);
        repeat (3) @(negedge clk);
        load_val(16'h9999, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        check("midreset anode", 32'(bus.anode), 32'hF);
        check("midreset Led_Disp", 32'(bus.Led_Disp), 32'h7F);
        check("midreset dp", 32'(bus.dp), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        slot_pins("post reset", 4'b1110, 7'b1000000);
        goto_slot(0);
        check("pending dropped", 32'(bus.Led_Disp), 32'(7'b1000000));
        repeat (24) @(negedge clk);
        slot_pins("pending dropped slot3", 4'b0111, 7'b1000000);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            bus.digits_in = 16'($urandom);
            bus.dp_in     = 4'($urandom);
            bus.load      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 63) == 0) bus.hex_mode = 1'($urandom);
            if ($urandom_range(0, 31) == 0) bus.brightness = 3'($urandom);
            reset = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        reset    = 1'b0;
        bus.load = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
